// File: rtl/serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo
// Description : Receive-side deserializer. Hunts for the COMMA symbol on any
//               bit boundary, locks after COMMA_COUNT aligned COMMAs, then
//               delivers every aligned non-COMMA symbol as data.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo #(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  COMMA       = 8'hBC,
    parameter int                COMMA_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic             active
);

    localparam int                 c_cnt_w        = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit     = c_cnt_w'(WIDTH - 1);
    localparam logic [3:0]         c_comma_target = 4'(COMMA_COUNT);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_LOCKING = 2'd1,
        S_ACTIVE  = 2'd2
    } state_t;

    state_t             r_state;
    // Only the newest WIDTH-1 bits are kept; the incoming bit completes the byte.
    logic [WIDTH-2:0]   r_sr;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [3:0]         r_com_cnt;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_valid_out;
    logic               r_byte_strobe;
    logic               r_active;

    logic [WIDTH-1:0]   w_nxt;
    logic               w_is_comma;
    logic               w_boundary;
    logic [3:0]         w_com_inc;

    assign w_nxt      = {r_sr, data_in};
    assign w_is_comma = (w_nxt == COMMA);
    assign w_boundary = (r_bit_cnt == c_last_bit);
    assign w_com_inc  = r_com_cnt + 4'd1;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state       <= S_SEARCH;
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_com_cnt     <= '0;
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_byte_strobe <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_sr          <= w_nxt[WIDTH-2:0];
            r_byte_strobe <= 1'b0;

            case (r_state)
                S_SEARCH: begin
                    if (w_is_comma) begin
                        r_bit_cnt <= '0;
                        r_com_cnt <= 4'd1;
                        if (COMMA_COUNT == 1) begin
                            r_state  <= S_ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state  <= S_LOCKING;
                        end
                    end
                end

                S_LOCKING: begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            r_com_cnt <= (w_com_inc >= c_comma_target) ? c_comma_target : w_com_inc;
                            if (w_com_inc >= c_comma_target) begin
                                r_state  <= S_ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            r_com_cnt <= '0;
                            r_state   <= S_SEARCH;
                        end
                    end
                end

                S_ACTIVE: begin
                    // Alignment is trusted once locked; garbage is passed as data.
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_boundary) begin
                        r_byte_strobe <= 1'b1;
                        if (w_is_comma) begin
                            r_valid_out <= 1'b0;
                        end else begin
                            r_data_out  <= w_nxt;
                            r_valid_out <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_SEARCH;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign byte_strobe = r_byte_strobe;
    assign active      = r_active;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo
// Description : Bench for serial_paralelo; COMMA_COUNT=4 and COMMA_COUNT=1
//               instances share one stream and are compared to a symbol model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;

    logic [7:0] w_dout [2];
    logic       w_valid [2];
    logic       w_strobe [2];
    logic       w_active [2];

    always #5 clk_32f = ~clk_32f;

    serial_paralelo #(.WIDTH(8), .COMMA(8'hBC), .COMMA_COUNT(4)) u_dut4 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (w_dout[0]),
        .valid_out   (w_valid[0]),
        .byte_strobe (w_strobe[0]),
        .active      (w_active[0])
    );

    serial_paralelo #(.WIDTH(8), .COMMA(8'hBC), .COMMA_COUNT(1)) u_dut1 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (w_dout[1]),
        .valid_out   (w_valid[1]),
        .byte_strobe (w_strobe[1]),
        .active      (w_active[1])
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 = hunting, 1 = counting commas, 2 = delivering.
    int cc [2] = '{4, 1};
    int m_byte [2], m_mode [2], m_since [2], m_runs [2];
    int e_data [2], e_valid [2], e_strobe [2], e_active [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit b);
        if (r) begin
            m_byte[i] = 0; m_mode[i] = 0; m_since[i] = 0; m_runs[i] = 0;
            e_data[i] = 0; e_valid[i] = 0; e_strobe[i] = 0; e_active[i] = 0;
        end else begin
            m_byte[i]   = (m_byte[i] * 2 + int'(b)) % 256;
            e_strobe[i] = 0;
            if (m_mode[i] == 0) begin
                if (m_byte[i] == 188) begin
                    m_since[i] = 0;
                    m_runs[i]  = 1;
                    m_mode[i]  = (cc[i] == 1) ? 2 : 1;
                    if (m_mode[i] == 2) e_active[i] = 1;
                end
            end else begin
                m_since[i]++;
                if (m_since[i] % 8 == 0) begin
                    if (m_mode[i] == 1) begin
                        if (m_byte[i] == 188) begin
                            m_runs[i] = (m_runs[i] + 1 > cc[i]) ? cc[i] : m_runs[i] + 1;
                            if (m_runs[i] == cc[i]) begin
                                m_mode[i]   = 2;
                                e_active[i] = 1;
                            end
                        end else begin
                            m_runs[i] = 0;
                            m_mode[i] = 0;
                        end
                    end else begin
                        e_strobe[i] = 1;
                        if (m_byte[i] != 188) begin
                            e_data[i]  = m_byte[i];
                            e_valid[i] = 1;
                        end else begin
                            e_valid[i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    // One serial bit: drive, clock, advance model, compare every output.
    task automatic step(input bit r, input bit b);
        reset   = r;
        data_in = b;
        @(posedge clk_32f);
        for (int i = 0; i < 2; i++) model_step(i, r, b);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cyc_data%0d", i),   int'(w_dout[i]),   e_data[i]);
            chk($sformatf("cyc_valid%0d", i),  int'(w_valid[i]),  e_valid[i]);
            chk($sformatf("cyc_strobe%0d", i), int'(w_strobe[i]), e_strobe[i]);
            chk($sformatf("cyc_active%0d", i), int'(w_active[i]), e_active[i]);
        end
    endtask

    task automatic send_bits(input int v, input int hi, input int lo);
        for (int k = hi; k >= lo; k--) step(1'b0, bit'((v >> k) & 1));
    endtask

    task automatic send_byte(input int v);
        send_bits(v, 7, 0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0);
    endtask

    initial begin
        #2;
        // 1: reset, 4 COMs, then data
        do_reset(3);
        chk("rst_data",   int'(w_dout[0]),   0);
        chk("rst_valid",  int'(w_valid[0]),  0);
        chk("rst_strobe", int'(w_strobe[0]), 0);
        chk("rst_active", int'(w_active[0]), 0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_bits(8'hBC, 7, 1);
        chk("s1_active_before", int'(w_active[0]), 0);
        send_bits(8'hBC, 0, 0);
        chk("s1_active_after", int'(w_active[0]), 1);
        send_byte(8'hAB);
        chk("s1_data",   int'(w_dout[0]),   8'hAB);
        chk("s1_valid",  int'(w_valid[0]),  1);
        chk("s1_strobe", int'(w_strobe[0]), 1);

        // 2: interrupted comma run
        do_reset(1);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'hAB);
        chk("s2_active_ab", int'(w_active[0]), 0);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        chk("s2_active", int'(w_active[0]), 1);
        send_byte(8'hCA);
        chk("s2_data",  int'(w_dout[0]),  8'hCA);
        chk("s2_valid", int'(w_valid[0]), 1);

        // 3: bit offset before alignment
        do_reset(1);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        send_byte(8'h12);
        chk("s3_data",  int'(w_dout[0]),  8'h12);
        chk("s3_valid", int'(w_valid[0]), 1);

        // 4: data, idle, data in ACTIVE
        send_byte(8'hAB);
        chk("s4_ab_data", int'(w_dout[0]), 8'hAB);
        send_byte(8'hBC);
        chk("s4_idle_valid", int'(w_valid[0]), 0);
        chk("s4_idle_data",  int'(w_dout[0]),  8'hAB);
        chk("s4_idle_strobe", int'(w_strobe[0]), 1);
        send_bits(8'hFA, 7, 7);
        chk("s4_mid_strobe", int'(w_strobe[0]), 0);
        send_bits(8'hFA, 6, 0);
        chk("s4_fa_data",  int'(w_dout[0]),  8'hFA);
        chk("s4_fa_valid", int'(w_valid[0]), 1);

        // 5: reset mid-byte in ACTIVE
        send_bits(8'h5A, 7, 4);
        step(1'b1, 1'b1);
        chk("s5_data",   int'(w_dout[0]),   0);
        chk("s5_valid",  int'(w_valid[0]),  0);
        chk("s5_active", int'(w_active[0]), 0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h55);
        chk("s5_nodata_valid",  int'(w_valid[0]),  0);
        chk("s5_nodata_active", int'(w_active[0]), 0);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        send_byte(8'h66);
        chk("s5_relock_data",  int'(w_dout[0]),  8'h66);
        chk("s5_relock_valid", int'(w_valid[0]), 1);

        // 6: single-comma lock instance
        do_reset(1);
        send_byte(8'hBC);
        send_byte(8'h33);
        chk("s6_active", int'(w_active[1]), 1);
        chk("s6_data",   int'(w_dout[1]),   8'h33);
        chk("s6_valid",  int'(w_valid[1]),  1);
        chk("s6_other_active", int'(w_active[0]), 0);

        // Randomized streams against the model
        for (int round = 0; round < 8; round++) begin
            do_reset(1);
            for (int k = 0; k < int'($urandom_range(0, 12)); k++) step(1'b0, 1'($urandom));
            for (int k = 0; k < int'($urandom_range(3, 5)); k++) send_byte(8'hBC);
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 99) == 0) step(1'b1, 1'b0);
                if ($urandom_range(0, 2) == 0) send_byte(8'hBC);
                else send_byte(int'($urandom_range(0, 255)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
